// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects four push-buttons
// and captures a shot (owner plus switch coordinates) when a fire button
// press is accepted. Every flop sits on the rising edge of clk and clears on
// a synchronous, active-high rst.
module btn_conditioner #(
  // Consecutive stable cycles needed before a debounced level changes (1..255).
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] sw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       shot_valid,
  output logic       shot_player,
  output logic [1:0] shot_x,
  output logic [1:0] shot_y
);

  // Button bit assignments.
  localparam int unsigned FIRE_A = 3;
  localparam int unsigned FIRE_B = 0;

  // shot_player encoding.
  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  // Threshold in the 8-bit width of the stability counters.
  localparam logic [7:0] THRESHOLD = 8'(DEBOUNCE_CYCLES);

  // Two-stage synchronizer registers (first stage can go metastable).
  logic [3:0] btn_meta;
  logic [3:0] btn_sync;
  logic [3:0] sw_meta;
  logic [3:0] sw_sync;

  // sync_ready[1] goes high once the synchronizer holds samples taken
  // entirely after reset; before that its zeros are reset values, not data.
  logic [1:0] sync_ready;

  // Per-channel stability counters and their incremented values.
  logic [3:0][7:0] stable_cnt;
  logic [3:0][7:0] cnt_inc;

  // Per-channel state of the debounce/edge logic.
  logic [3:0] differs;  // synchronized input disagrees with btn_level
  logic [3:0] toggle;   // btn_level flips at the coming edge
  logic [3:0] rising;   // the flip at the coming edge is 0 -> 1
  logic [3:0] armed;    // channel has seen a clean released state since reset
  logic [3:0] arm_set;  // channel becomes armed at the coming edge

  // Shot capture request for the coming edge.
  logic       fire_any;
  logic       next_player;

  // Synchronize the raw buttons and switches before anything else uses them.
  always_ff @(posedge clk) begin
    // NOTE: every clocked register is assigned with <= so all flops update
    // from the values sampled before the edge, independent of statement order.
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  // Track when the synchronizer pipeline has refilled with post-reset samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ready <= '0;
    end else begin
      sync_ready <= {sync_ready[0], 1'b1};
    end
  end

  // Decide per channel whether the level flips and whether it becomes armed.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path through this
    // block leaves a value unassigned, which would infer a latch.
    cnt_inc = '0;
    differs = '0;
    toggle  = '0;
    rising  = '0;
    arm_set = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_inc[i] = stable_cnt[i] + 8'd1;
      differs[i] = (btn_sync[i] != btn_level[i]);
      toggle[i]  = differs[i] && (cnt_inc[i] == THRESHOLD);
      rising[i]  = toggle[i] && !btn_level[i];
      arm_set[i] = sync_ready[1] && !btn_level[i] && !btn_sync[i];
    end
  end

  // Stability counters: clear when input matches the level or on a flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!differs[i] || toggle[i]) begin
          stable_cnt[i] <= '0;
        end else begin
          stable_cnt[i] <= cnt_inc[i];
        end
      end
    end
  end

  // Debounced levels flip once an input has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
    end else begin
      btn_level <= btn_level ^ toggle;
    end
  end

  // Arm bits latch on and stay set until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= '0;
    end else begin
      armed <= armed | arm_set;
    end
  end

  // One-cycle pulse coinciding with each armed 0 -> 1 level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_pulse <= '0;
    end else begin
      btn_pulse <= rising & armed;
    end
  end

  // Fire arbitration: player A wins a tie; the losing B press is dropped.
  always_comb begin
    fire_any    = btn_pulse[FIRE_A] || btn_pulse[FIRE_B];
    next_player = btn_pulse[FIRE_A] ? PLAYER_A : PLAYER_B;
  end

  // Register the shot one cycle after the fire pulse; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      shot_valid  <= 1'b0;
      shot_player <= PLAYER_A;
      shot_x      <= '0;
      shot_y      <= '0;
    end else if (fire_any) begin
      shot_valid  <= 1'b1;
      shot_player <= next_player;
      shot_x      <= sw_sync[3:2];
      shot_y      <= sw_sync[1:0];
    end else begin
      shot_valid  <= 1'b0;
    end
  end

endmodule
